lights_occupancy_ctrl: RTL and testbench
========================================

// Module: lights_occupancy_ctrl
// PURPOSE
//  Sequential controller for a room's lighting driver. Adds a debounced dark sensor
//  and a hold timer to the basic (dark & movement) | force_on rule, so lights stay
//  on briefly after motion stops. Sits between raw sensor inputs and the lamp driver.
//  Exposes its state and timer for status and debug.
// PARAMETERS
//  HOLD_CYCLES       4  cycles lights stay on after movement stops (>=1)
//  DARK_FILT_CYCLES  3  consecutive differing samples before filtered dark flips (>=1)
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  reset           in   1   synchronous, active-high reset
//  dark            in   1   raw ambient-dark sensor
//  movement        in   1   raw motion sensor
//  force_on        in   1   manual override; lights on while asserted
//  turn_on_lights  out  1   lamp enable
//  state           out  2   FSM state: 0 IDLE, 1 ON, 2 HOLD, 3 FORCED
//  timer           out  TW  hold countdown; TW = $clog2(HOLD_CYCLES+1)
// BEHAVIOUR
//  - Reset: state=IDLE, timer=0, dark_filt=0, filter count=0, turn_on_lights=0.
//    Reset overrides all inputs, including force_on, and applies mid-operation.
//  - Dark filter: count increments on each edge where dark != dark_filt and clears
//    when they match. When count would reach DARK_FILT_CYCLES, dark_filt <= dark and
//    count <= 0. The new value is visible to the FSM on the following edge.
//    With DARK_FILT_CYCLES=1, dark_filt is dark delayed by one cycle.
//  - FSM, evaluated on each edge; the first matching rule wins:
//    any state: force_on=1 -> FORCED, timer=0
//    FORCED: force_on=0 -> HOLD with timer=HOLD_CYCLES if dark_filt, else IDLE
//    IDLE:   dark_filt & movement -> ON; else stay
//    ON:     !dark_filt -> IDLE; !movement -> HOLD, timer=HOLD_CYCLES; else stay
//    HOLD:   !dark_filt -> IDLE, timer=0; movement -> ON, timer=0;
//            timer==1 -> IDLE, timer=0; else timer <= timer-1
//  - Daylight (dark_filt=0) ends ON and HOLD immediately. FORCED ignores dark.
//  - turn_on_lights = (state != IDLE). This is a Moore output, so there is one cycle
//    of latency from a sampled input to the lamp.
//  - timer is 0 in every state except HOLD. In HOLD it runs HOLD_CYCLES..1, which
//    gives exactly HOLD_CYCLES lit HOLD cycles when no movement occurs.
//  - Simultaneous events: force_on beats everything; in HOLD, daylight beats movement,
//    and movement beats timer expiry.
// STRUCTURE
//  - Shared package lights_pkg: typedef enum logic [1:0] lights_state_t
//    {IDLE, ON, HOLD, FORCED}. Reuse it in benches and status decoders.
//  - Sub-module lights_dark_filter (clk, reset, dark -> dark_filt), parameterized by
//    DARK_FILT_CYCLES. The FSM, timer and output decode live in the top module.
// TESTING (defaults HOLD_CYCLES=4, DARK_FILT_CYCLES=3; edges counted after reset)
//  1 dark=1, movement=1 held from reset -> dark_filt=1 after edge 3; state=ON and
//    lights=1 after edge 4; lights=0 before that.
//  2 In ON, drop movement -> HOLD with timer 4,3,2,1 on successive cycles, lights=1;
//    IDLE and lights=0 on the 5th cycle.
//  3 In HOLD at timer=2, pulse movement=1 -> ON, timer=0; drop movement -> timer
//    reloads to 4.
//  4 dark=0, force_on=1 for 3 cycles -> FORCED, lights=1 from the next cycle;
//    force_on=0 -> IDLE next edge. Repeat with dark_filt=1 -> HOLD, timer=4.
//  5 Glitch: dark=1 for 2 cycles then 0, movement=1 throughout -> dark_filt stays 0,
//    state IDLE, lights=0.
//  6 reset=1 during HOLD with force_on=1 -> next cycle state=IDLE, timer=0, lights=0;
//    after reset deasserts with force_on=1 -> FORCED one edge later.

Source files
------------

// File: rtl/lights_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lights_pkg
//  Description : Shared state encoding for the lighting occupancy controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package lights_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ON     = 2'd1,
        HOLD   = 2'd2,
        FORCED = 2'd3
    } lights_state_t;

endpackage : lights_pkg
`default_nettype wire

// File: rtl/lights_dark_filter.sv
`default_nettype none
// ============================================================================
//  Module      : lights_dark_filter
//  Description : Debounces the raw dark sensor; flips only after a run of
//                consecutive samples disagreeing with the filtered value.
//  Revision    : 1.0 - initial release
// ============================================================================
module lights_dark_filter #(
    parameter int DARK_FILT_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic dark,
    output logic dark_filt
);
    import lights_pkg::*;

    localparam int CW = $clog2(DARK_FILT_CYCLES + 1);

    logic          r_filt;
    logic [CW-1:0] r_count;
    logic          w_filt_nxt;
    logic [CW-1:0] w_count_nxt;

    always_comb begin
        w_filt_nxt  = r_filt;
        w_count_nxt = '0;
        if (dark != r_filt) begin
            // The sample completing the run flips the output and restarts the count
            if (r_count == CW'(DARK_FILT_CYCLES - 1)) begin
                w_filt_nxt  = dark;
                w_count_nxt = '0;
            end else begin
                w_count_nxt = r_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt  <= 1'b0;
            r_count <= '0;
        end else begin
            r_filt  <= w_filt_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign dark_filt = r_filt;

endmodule : lights_dark_filter
`default_nettype wire

// File: rtl/lights_occupancy_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lights_occupancy_ctrl
//  Description : Room lighting controller: debounced dark sensing, motion hold
//                timer and manual override, with Moore lamp output.
//  Revision    : 1.0 - initial release
// ============================================================================
module lights_occupancy_ctrl #(
    parameter int HOLD_CYCLES      = 4,
    parameter int DARK_FILT_CYCLES = 3,
    parameter int TW               = $clog2(HOLD_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dark,
    input  logic          movement,
    input  logic          force_on,
    output logic          turn_on_lights,
    output logic [1:0]    state,
    output logic [TW-1:0] timer
);
    import lights_pkg::*;

    localparam logic [TW-1:0] C_HOLD_LOAD = TW'(HOLD_CYCLES);

    logic          w_dark_filt;
    lights_state_t r_state;
    lights_state_t w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;

    lights_dark_filter #(
        .DARK_FILT_CYCLES (DARK_FILT_CYCLES)
    ) u_dark_filter (
        .clk       (clk),
        .reset     (reset),
        .dark      (dark),
        .dark_filt (w_dark_filt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (force_on) begin
            w_state_nxt = FORCED;
            w_timer_nxt = '0;
        end else begin
            unique case (r_state)
                FORCED: begin
                    if (w_dark_filt) begin
                        w_state_nxt = HOLD;
                        w_timer_nxt = C_HOLD_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                        w_timer_nxt = '0;
                    end
                end
                IDLE: begin
                    w_timer_nxt = '0;
                    if (w_dark_filt && movement) begin
                        w_state_nxt = ON;
                    end
                end
                ON: begin
                    if (!w_dark_filt) begin
                        w_state_nxt = IDLE;
                        w_timer_nxt = '0;
                    end else if (!movement) begin
                        w_state_nxt = HOLD;
                        w_timer_nxt = C_HOLD_LOAD;
                    end
                end
                HOLD: begin
                    // Daylight outranks movement, which outranks expiry
                    if (!w_dark_filt || (!movement && r_timer == TW'(1))) begin
                        w_state_nxt = IDLE;
                        w_timer_nxt = '0;
                    end else if (movement) begin
                        w_state_nxt = ON;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer - TW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    assign state          = r_state;
    assign timer          = r_timer;
    assign turn_on_lights = (r_state != IDLE);

endmodule : lights_occupancy_ctrl
`default_nettype wire

// File: tb/tb_lights_occupancy_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lights_occupancy_ctrl
//  Description : Directed and randomized bench for lights_occupancy_ctrl with
//                a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lights_occupancy_ctrl;
    localparam int C_HOLD = 4;
    localparam int C_FILT = 3;
    localparam int TW     = $clog2(C_HOLD + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dark = 1'b0;
    logic          movement = 1'b0;
    logic          force_on = 1'b0;
    logic          turn_on_lights;
    logic [1:0]    state;
    logic [TW-1:0] timer;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 dark room, 1 occupied, 2 lingering, 3 manual
    int m_mode = 0;
    int m_left = 0;
    bit m_filt = 1'b0;
    bit m_run[$];

    lights_occupancy_ctrl #(
        .HOLD_CYCLES      (C_HOLD),
        .DARK_FILT_CYCLES (C_FILT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dark           (dark),
        .movement       (movement),
        .force_on       (force_on),
        .turn_on_lights (turn_on_lights),
        .state          (state),
        .timer          (timer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit d, input bit m, input bit f);
        if (r) begin
            m_mode = 0; m_left = 0; m_filt = 0; m_run.delete();
            return;
        end
        if (f) begin
            m_mode = 3; m_left = 0;
        end else if (m_mode == 3) begin
            m_mode = m_filt ? 2 : 0;
            m_left = m_filt ? C_HOLD : 0;
        end else if (m_mode == 0) begin
            if (m_filt && m) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!m_filt) m_mode = 0;
            else if (!m) begin m_mode = 2; m_left = C_HOLD; end
        end else begin
            if (!m_filt)          begin m_mode = 0; m_left = 0; end
            else if (m)           begin m_mode = 1; m_left = 0; end
            else if (m_left == 1) begin m_mode = 0; m_left = 0; end
            else m_left = m_left - 1;
        end
        // Filter: a run of C_FILT samples disagreeing with the output flips it
        if (d == m_filt) m_run.delete();
        else begin
            m_run.push_back(d);
            if (m_run.size() == C_FILT) begin
                m_filt = d;
                m_run.delete();
            end
        end
    endtask

    task automatic step(input bit r, input bit d, input bit m, input bit f);
        @(negedge clk);
        reset = r; dark = d; movement = m; force_on = f;
        @(posedge clk);
        model_edge(r, d, m, f);
        #1;
        chk("state",  int'(state),          m_mode);
        chk("timer",  int'(timer),          m_left);
        chk("lights", int'(turn_on_lights), (m_mode != 0) ? 1 : 0);
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_state", int'(state), 0);
        chk("rst_timer", int'(timer), 0);
        chk("rst_lights", int'(turn_on_lights), 0);

        // 1: dark+movement from reset, lamp comes on after edge 4
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0);
            chk("t1_dark_lights", int'(turn_on_lights), 0);
        end
        step(0, 1, 1, 0);
        chk("t1_on_state", int'(state), 1);
        chk("t1_on_lights", int'(turn_on_lights), 1);

        // 2: hold countdown then off
        for (int i = C_HOLD; i >= 1; i--) begin
            step(0, 1, 0, 0);
            chk("t2_hold_state", int'(state), 2);
            chk("t2_hold_timer", int'(timer), i);
            chk("t2_hold_lights", int'(turn_on_lights), 1);
        end
        step(0, 1, 0, 0);
        chk("t2_idle_state", int'(state), 0);
        chk("t2_idle_lights", int'(turn_on_lights), 0);

        // 3: movement during hold returns to ON, release reloads
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("t3_timer2", int'(timer), 2);
        step(0, 1, 1, 0);
        chk("t3_on_state", int'(state), 1);
        chk("t3_on_timer", int'(timer), 0);
        step(0, 1, 0, 0);
        chk("t3_reload", int'(timer), C_HOLD);

        // 4: override in daylight, then in dark
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            chk("t4_forced", int'(state), 3);
            chk("t4_forced_lights", int'(turn_on_lights), 1);
        end
        step(0, 0, 0, 0);
        chk("t4_day_release", int'(state), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        chk("t4_dark_release", int'(state), 2);
        chk("t4_dark_timer", int'(timer), C_HOLD);

        // 6: reset beats force_on mid-hold
        step(1, 1, 0, 1);
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_timer", int'(timer), 0);
        chk("t6_rst_lights", int'(turn_on_lights), 0);
        step(0, 1, 0, 1);
        chk("t6_forced", int'(state), 3);

        // 5: dark glitch shorter than the filter
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            chk("t5_glitch_state", int'(state), 0);
            chk("t5_glitch_lights", int'(turn_on_lights), 0);
        end

        // Randomized phase, dark held in runs to exercise the filter
        begin
            bit rd = 0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 5) == 0) rd = ~rd;
                step(($urandom_range(0, 59) == 0),
                     rd,
                     ($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 11) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_lights_occupancy_ctrl
`default_nettype wire
